// File: rtl/sdram_fill_engine.sv
// Rectangle-fill DMA engine: writes a constant 16-bit value over a WIDTH x HEIGHT
// word rectangle through one SDRAM arbiter port, programmed via the I/O register bus.
module sdram_fill_engine #(
   parameter logic [11:0] BASE_ADDR = 12'h300,
   parameter int unsigned DIM_W     = 12
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        io_write_valid_i,
   input  logic        io_read_valid_i,
   input  logic [11:0] io_addr_i,
   input  logic [31:0] io_wdata_i,
   output logic [31:0] io_rdata_o,
   output logic        sdram_wr_o,
   output logic [23:0] sdram_addr_x16_o,
   output logic [15:0] sdram_wdata_o,
   output logic [1:0]  sdram_wmask_o,
   input  logic        sdram_ack_i,
   output logic        busy_o,
   output logic        done_o
);

   localparam int unsigned AW = 24;
   localparam int unsigned DW = 16;
   localparam logic [11:0] A_CTRL   = 12'(BASE_ADDR + 12'h000);
   localparam logic [11:0] A_DST    = 12'(BASE_ADDR + 12'h004);
   localparam logic [11:0] A_SIZE   = 12'(BASE_ADDR + 12'h008);
   localparam logic [11:0] A_STRIDE = 12'(BASE_ADDR + 12'h00C);
   localparam logic [11:0] A_VALUE  = 12'(BASE_ADDR + 12'h010);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t             state_q, state_d;
   logic [AW-1:0]      dst_q, dst_d, stride_q, stride_d;
   logic [AW-1:0]      row_base_q, row_base_d, addr_q, addr_d;
   logic [DIM_W-1:0]   width_q, width_d, height_q, height_d;
   logic [DIM_W-1:0]   x_q, x_d, y_q, y_d;
   logic [DW-1:0]      value_q, value_d, wdata_q, wdata_d;
   logic [1:0]         wmask_q, wmask_d;
   logic               wr_q, wr_d, busy_q, busy_d, done_q, done_d;
   logic               done_pulse_q, done_pulse_d;
   logic [31:0]        rdata_q, rdata_d;

   logic               ctrl_wr, start, abort, last_x, last_word;
   logic               unused_inputs;

   assign unused_inputs = ^{io_read_valid_i, io_wdata_i[31:28]};

   assign ctrl_wr   = io_write_valid_i && (io_addr_i == A_CTRL);
   assign start     = ctrl_wr && io_wdata_i[0];
   assign abort     = ctrl_wr && io_wdata_i[1];
   assign last_x    = (x_q == DIM_W'(width_q - DIM_W'(1)));
   assign last_word = last_x && (y_q == DIM_W'(height_q - DIM_W'(1)));

   always_comb begin
      state_d      = state_q;
      dst_d        = dst_q;
      stride_d     = stride_q;
      width_d      = width_q;
      height_d     = height_q;
      value_d      = value_q;
      row_base_d   = row_base_q;
      addr_d       = addr_q;
      x_d          = x_q;
      y_d          = y_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      wr_d         = wr_q;
      busy_d       = busy_q;
      done_d       = done_q;
      done_pulse_d = 1'b0;
      rdata_d      = '0;

      // Configuration is frozen while a fill is in flight
      if (io_write_valid_i && state_q == S_IDLE) begin
         case (io_addr_i)
            A_DST:    dst_d    = io_wdata_i[AW-1:0];
            A_SIZE: begin
               width_d  = io_wdata_i[DIM_W-1:0];
               height_d = io_wdata_i[16+DIM_W-1:16];
            end
            A_STRIDE: stride_d = io_wdata_i[AW-1:0];
            A_VALUE:  value_d  = io_wdata_i[DW-1:0];
            default: ;
         endcase
      end

      case (io_addr_i)
         A_CTRL:   rdata_d = {30'b0, done_q, busy_q};
         A_DST:    rdata_d = 32'(dst_q);
         A_SIZE: begin
            rdata_d[DIM_W-1:0]     = width_q;
            rdata_d[16+DIM_W-1:16] = height_q;
         end
         A_STRIDE: rdata_d = 32'(stride_q);
         A_VALUE:  rdata_d = 32'(value_q);
         default:  rdata_d = '0;
      endcase

      case (state_q)
         S_IDLE: begin
            if (start) begin
               done_d = 1'b0;
               if (width_q == '0 || height_q == '0) begin
                  done_d       = 1'b1;
                  done_pulse_d = 1'b1;
               end else begin
                  state_d    = S_RUN;
                  row_base_d = dst_q;
                  addr_d     = dst_q;
                  x_d        = '0;
                  y_d        = '0;
                  wdata_d    = value_q;
                  wmask_d    = 2'b11;
                  wr_d       = 1'b1;
                  busy_d     = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (sdram_ack_i) begin
               if (last_word || abort) begin
                  // Completion takes priority over an abort landing on the last ack
                  state_d      = S_IDLE;
                  wr_d         = 1'b0;
                  wmask_d      = 2'b00;
                  busy_d       = 1'b0;
                  done_d       = last_word;
                  done_pulse_d = last_word;
               end else if (!last_x) begin
                  x_d    = DIM_W'(x_q + DIM_W'(1));
                  addr_d = AW'(addr_q + AW'(1));
               end else begin
                  x_d        = '0;
                  y_d        = DIM_W'(y_q + DIM_W'(1));
                  row_base_d = AW'(row_base_q + stride_q);
                  addr_d     = AW'(row_base_q + stride_q);
               end
            end else if (abort) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (sdram_ack_i) begin
               state_d = S_IDLE;
               wr_d    = 1'b0;
               wmask_d = 2'b00;
               busy_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         dst_q        <= '0;
         stride_q     <= '0;
         width_q      <= '0;
         height_q     <= '0;
         value_q      <= '0;
         row_base_q   <= '0;
         addr_q       <= '0;
         x_q          <= '0;
         y_q          <= '0;
         wdata_q      <= '0;
         wmask_q      <= 2'b00;
         wr_q         <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         done_pulse_q <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         dst_q        <= dst_d;
         stride_q     <= stride_d;
         width_q      <= width_d;
         height_q     <= height_d;
         value_q      <= value_d;
         row_base_q   <= row_base_d;
         addr_q       <= addr_d;
         x_q          <= x_d;
         y_q          <= y_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
         wr_q         <= wr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         done_pulse_q <= done_pulse_d;
         rdata_q      <= rdata_d;
      end
   end

   assign io_rdata_o       = rdata_q;
   assign sdram_wr_o       = wr_q;
   assign sdram_addr_x16_o = addr_q;
   assign sdram_wdata_o    = wdata_q;
   assign sdram_wmask_o    = wmask_q;
   assign busy_o           = busy_q;
   assign done_o           = done_pulse_q;

endmodule

// File: tb/tb_sdram_fill_engine.sv
// Scoreboard bench for sdram_fill_engine: expected writes are queued by the stimulus,
// and a monitor pops and compares each accepted SDRAM write.
module tb_sdram_fill_engine;

   localparam logic [11:0] A_CTRL   = 12'h300;
   localparam logic [11:0] A_DST    = 12'h304;
   localparam logic [11:0] A_SIZE   = 12'h308;
   localparam logic [11:0] A_STRIDE = 12'h30C;
   localparam logic [11:0] A_VALUE  = 12'h310;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        io_write_valid_i, io_read_valid_i;
   logic [11:0] io_addr_i;
   logic [31:0] io_wdata_i, io_rdata_o;
   logic        sdram_wr_o, sdram_ack_i, busy_o, done_o;
   logic [23:0] sdram_addr_x16_o;
   logic [15:0] sdram_wdata_o;
   logic [1:0]  sdram_wmask_o;

   always #5 clk = ~clk;

   sdram_fill_engine #(.BASE_ADDR(12'h300), .DIM_W(12)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .io_write_valid_i(io_write_valid_i), .io_read_valid_i(io_read_valid_i),
      .io_addr_i(io_addr_i), .io_wdata_i(io_wdata_i), .io_rdata_o(io_rdata_o),
      .sdram_wr_o(sdram_wr_o), .sdram_addr_x16_o(sdram_addr_x16_o),
      .sdram_wdata_o(sdram_wdata_o), .sdram_wmask_o(sdram_wmask_o),
      .sdram_ack_i(sdram_ack_i), .busy_o(busy_o), .done_o(done_o)
   );

   typedef struct packed {
      logic [23:0] addr;
      logic [15:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  n_cmp = 0, n_err = 0;
   int  cyc = 0, n_writes = 0, n_done = 0, n_busy = 0;
   int  last_ack_cyc = 0, last_done_cyc = 0;
   int  ack_budget = -1, max_dly = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   // Ack driver: acknowledges the pending request after a random 0..max_dly cycle delay
   initial begin
      int  dly;
      bit  need_new;
      dly = 0;
      need_new = 1'b1;
      sdram_ack_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (sdram_ack_i) need_new = 1'b1;
         if (rst_i || !sdram_wr_o || ack_budget == 0) begin
            sdram_ack_i = 1'b0;
         end else begin
            if (need_new) begin
               dly = (max_dly == 0) ? 0 : int'($urandom_range(max_dly, 0));
               need_new = 1'b0;
            end
            if (dly == 0) begin
               sdram_ack_i = 1'b1;
               if (ack_budget > 0) ack_budget--;
            end else begin
               sdram_ack_i = 1'b0;
               dly--;
            end
         end
      end
   end

   // Monitor: compares accepted writes and checks request stability while unacked
   initial begin
      bit          prev_pend;
      logic [23:0] prev_addr;
      logic [15:0] prev_data;
      wr_t         e;
      prev_pend = 1'b0;
      prev_addr = '0;
      prev_data = '0;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            prev_pend = 1'b0;
         end else begin
            if (sdram_wr_o && prev_pend) begin
               check("hold_addr", 32'(sdram_addr_x16_o), 32'(prev_addr));
               check("hold_data", 32'(sdram_wdata_o), 32'(prev_data));
            end
            if (sdram_wr_o && sdram_ack_i) begin
               n_writes++;
               last_ack_cyc = cyc;
               check("wmask", 32'(sdram_wmask_o), 32'h3);
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none",
                           sdram_addr_x16_o, sdram_wdata_o);
               end else begin
                  e = exp_q.pop_front();
                  check("wr_addr", 32'(sdram_addr_x16_o), 32'(e.addr));
                  check("wr_data", 32'(sdram_wdata_o), 32'(e.data));
               end
            end
            prev_pend = sdram_wr_o && !sdram_ack_i;
            prev_addr = sdram_addr_x16_o;
            prev_data = sdram_wdata_o;
            if (done_o) begin
               n_done++;
               last_done_cyc = cyc;
            end
            if (busy_o) n_busy++;
         end
      end
   end

   task automatic io_wr(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      io_write_valid_i = 1'b1;
      io_addr_i = a;
      io_wdata_i = d;
      @(negedge clk);
      io_write_valid_i = 1'b0;
   endtask

   task automatic io_rd(input string name, input logic [11:0] a, input logic [31:0] exp);
      @(negedge clk);
      io_addr_i = a;
      io_read_valid_i = 1'b1;
      @(negedge clk);
      io_read_valid_i = 1'b0;
      check(name, io_rdata_o, exp);
   endtask

   task automatic cfg(input logic [23:0] dst, input int w, input int h,
                      input logic [23:0] stride, input logic [15:0] val);
      io_wr(A_DST, 32'(dst));
      io_wr(A_SIZE, (32'(h) << 16) | 32'(w));
      io_wr(A_STRIDE, 32'(stride));
      io_wr(A_VALUE, 32'(val));
   endtask

   task automatic push_rect(input logic [23:0] dst, input int w, input int h,
                            input logic [23:0] stride, input logic [15:0] val);
      logic [23:0] row;
      row = dst;
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) exp_q.push_back('{addr: 24'(row + 24'(x)), data: val});
         row = 24'(row + stride);
      end
   endtask

   task automatic push_one(input logic [23:0] a, input logic [15:0] d);
      exp_q.push_back('{addr: a, data: d});
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 2000 && busy_o; i++) @(negedge clk);
      check(name, 32'(busy_o), 32'h0);
   endtask

   task automatic wait_writes(input string name, input int target);
      for (int i = 0; i < 2000 && n_writes < target; i++) @(negedge clk);
      check(name, 32'(n_writes >= target), 32'h1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, d0, b0, c0;
      rst_i = 1'b1;
      io_write_valid_i = 1'b0;
      io_read_valid_i = 1'b0;
      io_addr_i = '0;
      io_wdata_i = '0;
      repeat (3) @(negedge clk);
      check("rst_wr", 32'(sdram_wr_o), 32'h0);
      check("rst_busy", 32'(busy_o), 32'h0);
      check("rst_done", 32'(done_o), 32'h0);
      check("rst_addr", 32'(sdram_addr_x16_o), 32'h0);
      check("rst_wdata", 32'(sdram_wdata_o), 32'h0);
      check("rst_wmask", 32'(sdram_wmask_o), 32'h0);
      check("rst_rdata", io_rdata_o, 32'h0);
      rst_i = 1'b0;
      io_rd("rst_status", A_CTRL, 32'h0);

      // 1: 4x2 fill, ack every cycle
      cfg(24'h001000, 4, 2, 24'd640, 16'hF800);
      io_rd("t1_size_rb", A_SIZE, 32'h0002_0004);
      for (int i = 0; i < 4; i++) push_one(24'h001000 + 24'(i), 16'hF800);
      for (int i = 0; i < 4; i++) push_one(24'h001280 + 24'(i), 16'hF800);
      n0 = n_writes; d0 = n_done; b0 = n_busy;
      io_wr(A_CTRL, 32'h1);
      check("t1_first_wr", 32'(sdram_wr_o), 32'h1);
      check("t1_first_addr", 32'(sdram_addr_x16_o), 32'h001000);
      wait_idle("t1_idle");
      @(negedge clk);
      check("t1_nwrites", 32'(n_writes - n0), 32'd8);
      check("t1_ndone", 32'(n_done - d0), 32'd1);
      check("t1_done_cycle", 32'(last_done_cyc), 32'(last_ack_cyc + 1));
      check("t1_busy_cycles", 32'(n_busy - b0), 32'd8);
      check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
      io_rd("t1_status", A_CTRL, 32'h2);

      // 2: same fill with random ack latency
      max_dly = 5;
      for (int i = 0; i < 4; i++) push_one(24'h001000 + 24'(i), 16'hF800);
      for (int i = 0; i < 4; i++) push_one(24'h001280 + 24'(i), 16'hF800);
      n0 = n_writes; d0 = n_done;
      io_wr(A_CTRL, 32'h1);
      wait_idle("t2_idle");
      @(negedge clk);
      check("t2_nwrites", 32'(n_writes - n0), 32'd8);
      check("t2_ndone", 32'(n_done - d0), 32'd1);
      check("t2_queue_empty", 32'(exp_q.size()), 32'd0);
      max_dly = 0;

      // 3: zero width completes immediately
      cfg(24'h000100, 0, 5, 24'd0, 16'h1111);
      n0 = n_writes;
      io_wr(A_CTRL, 32'h1);
      check("t3_done_pulse", 32'(done_o), 32'h1);
      check("t3_no_wr", 32'(sdram_wr_o), 32'h0);
      check("t3_not_busy", 32'(busy_o), 32'h0);
      @(negedge clk);
      check("t3_pulse_one", 32'(done_o), 32'h0);
      io_rd("t3_status", A_CTRL, 32'h2);
      check("t3_nwrites", 32'(n_writes - n0), 32'd0);

      // 4: abort while the 4th write is unacked
      cfg(24'h004000, 16, 1, 24'd0, 16'h5555);
      for (int i = 0; i < 4; i++) push_one(24'h004000 + 24'(i), 16'h5555);
      n0 = n_writes; d0 = n_done;
      ack_budget = 3;
      io_wr(A_CTRL, 32'h1);
      wait_writes("t4_three_acks", n0 + 3);
      repeat (2) @(negedge clk);
      io_wr(A_CTRL, 32'h2);
      check("t4_drain_wr", 32'(sdram_wr_o), 32'h1);
      check("t4_drain_busy", 32'(busy_o), 32'h1);
      check("t4_drain_addr", 32'(sdram_addr_x16_o), 32'h004003);
      repeat (3) @(negedge clk);
      check("t4_still_held", 32'(sdram_wr_o), 32'h1);
      ack_budget = 1;
      wait_idle("t4_idle");
      repeat (2) @(negedge clk);
      check("t4_nwrites", 32'(n_writes - n0), 32'd4);
      check("t4_no_done", 32'(n_done - d0), 32'd0);
      check("t4_wr_low", 32'(sdram_wr_o), 32'h0);
      io_rd("t4_status", A_CTRL, 32'h0);
      ack_budget = -1;

      // 5: 24-bit address wrap
      cfg(24'hFFFFFE, 4, 1, 24'd0, 16'h0F0F);
      push_one(24'hFFFFFE, 16'h0F0F);
      push_one(24'hFFFFFF, 16'h0F0F);
      push_one(24'h000000, 16'h0F0F);
      push_one(24'h000001, 16'h0F0F);
      n0 = n_writes;
      io_wr(A_CTRL, 32'h1);
      wait_idle("t5_idle");
      @(negedge clk);
      check("t5_nwrites", 32'(n_writes - n0), 32'd4);

      // 6a: config writes and START while busy are ignored
      max_dly = 2;
      cfg(24'h002000, 8, 2, 24'd16, 16'h00AA);
      push_rect(24'h002000, 8, 2, 24'd16, 16'h00AA);
      n0 = n_writes; d0 = n_done;
      io_wr(A_CTRL, 32'h1);
      repeat (2) @(negedge clk);
      io_wr(A_VALUE, 32'h1234);
      io_wr(A_CTRL, 32'h1);
      io_rd("t6_value_kept", A_VALUE, 32'h00AA);
      wait_idle("t6_idle");
      @(negedge clk);
      check("t6_nwrites", 32'(n_writes - n0), 32'd16);
      check("t6_ndone", 32'(n_done - d0), 32'd1);
      check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

      // 6b: reset in the middle of a fill
      max_dly = 0;
      cfg(24'h003000, 16, 4, 24'd16, 16'h7777);
      push_rect(24'h003000, 16, 4, 24'd16, 16'h7777);
      c0 = n_writes;
      io_wr(A_CTRL, 32'h1);
      wait_writes("t6_some_writes", c0 + 5);
      ack_budget = 0;
      repeat (2) @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      check("t6_rst_wr", 32'(sdram_wr_o), 32'h0);
      check("t6_rst_busy", 32'(busy_o), 32'h0);
      check("t6_rst_addr", 32'(sdram_addr_x16_o), 32'h0);
      check("t6_rst_wmask", 32'(sdram_wmask_o), 32'h0);
      rst_i = 1'b0;
      exp_q.delete();
      ack_budget = -1;
      io_rd("t6_dst_cleared", A_DST, 32'h0);
      io_rd("t6_status", A_CTRL, 32'h0);
      io_rd("t6_unmapped", 12'h314, 32'h0);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sdram_fill_engine.md
Name: sdram_fill_engine

Overview:
- CPU-programmable rectangle-fill DMA engine; writes a constant 16-bit value over a W x H word rectangle in SDRAM, e.g. framebuffer clear or solid box.
- Configured through the memory controller's I/O register bus.
- Issues writes on one SDRAM arbiter requester port, alongside the CPU and video ports.
- Frees the CPU from per-pixel store loops.

Parameters:
BASE_ADDR, 12'h300, I/O byte offset of register block (bits [11:0] of io address).
DIM_W, 12, width in bits of WIDTH and HEIGHT fields.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
io_write_valid_i  in  1  one-cycle I/O write strobe
io_read_valid_i  in  1  one-cycle I/O read strobe (informational only)
io_addr_i  in  12  I/O byte address
io_wdata_i  in  32  I/O write data
io_rdata_o  out  32  registered read data for io_addr_i
sdram_wr_o  out  1  write request
sdram_addr_x16_o  out  24  word address
sdram_wdata_o  out  16  write data
sdram_wmask_o  out  2  byte mask, always 2'b11 when sdram_wr_o=1
sdram_ack_i  in  1  one-cycle acceptance of current write
busy_o  out  1  fill in progress
done_o  out  1  one-cycle pulse on normal completion

Behaviour:
- Register map, offsets from BASE_ADDR:
  - +0x00 W: CTRL. Bit0 START, bit1 ABORT.
  - +0x00 R: STATUS = {30'b0, done, busy}.
  - +0x04 DST[23:0] (RW).
  - +0x08 SIZE (RW): WIDTH [DIM_W-1:0], HEIGHT [16+DIM_W-1:16].
  - +0x0C STRIDE[23:0] (RW), in words.
  - +0x10 VALUE[15:0] (RW).
- Other bits read 0. Unmapped offsets read 0.
- io_rdata_o is updated every cycle from io_addr_i, giving 1-cycle read latency.
- Reset values: all config regs 0; busy, done, done_o, sdram_wr_o = 0; sdram_addr_x16_o, sdram_wdata_o = 0; sdram_wmask_o = 2'b00; io_rdata_o = 0; state IDLE.
- Writes to DST/SIZE/STRIDE/VALUE while busy are ignored. START while busy is ignored.
- FSM states: IDLE, RUN, DRAIN.
- IDLE, on START write (cycle N):
  - Clear done.
  - If WIDTH=0 or HEIGHT=0: done=1 and done_o pulses in cycle N+1. No SDRAM writes.
  - Otherwise: latch row_base=DST, x=0, y=0. Enter RUN.
  - In cycle N+1: busy=1, sdram_wr_o=1, addr=DST, wdata=VALUE, wmask=2'b11.
- RUN:
  - sdram_wr_o stays high. addr/wdata/wmask are held stable until sdram_ack_i=1.
  - On ack, if not on the last word: advance.
    - If x<WIDTH-1: x+1, addr+1.
    - Else: x=0, y+1, row_base += STRIDE, addr = new row_base.
    - The next request is presented the following cycle with wr still high, so back-to-back acks are allowed.
  - On ack of the last word (x=WIDTH-1, y=HEIGHT-1): next cycle sdram_wr_o=0, busy=0, done=1, done_o=1 for one cycle, state IDLE.
- ABORT:
  - In RUN with ack same cycle: stop after that write. Next cycle wr=0, busy=0, done stays 0.
  - In RUN without ack: enter DRAIN.
  - DRAIN holds the request unchanged until ack, then goes to IDLE. done=0, no done_o.
  - sdram_wr_o never drops before ack.
  - ABORT in IDLE: no effect.
- ABORT together with ack of the last word: counts as completion (done=1, done_o).
- START and ABORT both set in one write: ABORT wins if busy; otherwise START.
- Address arithmetic is modulo 2^24 (wraps from 0xFFFFFF to 0x000000). STRIDE is unsigned.
- Total writes = WIDTH*HEIGHT. With ack every cycle, busy lasts exactly WIDTH*HEIGHT cycles.
- rst_i mid-operation: next cycle all outputs are at reset values. A pending request is dropped and the arbiter must tolerate this.

Test Plan:
1. DST=0x001000, WIDTH=4, HEIGHT=2, STRIDE=640, VALUE=0xF800, ack every cycle:
   - Writes to 0x1000–0x1003 and 0x1280–0x1283, 8 writes total, wdata 0xF800, wmask 3.
   - done_o pulses the cycle after the 8th ack.
   - STATUS read returns 0x2.
2. Same config, ack delayed randomly 0–5 cycles:
   - addr/wdata stable while wr=1 and unacked.
   - Identical address sequence and write count.
3. WIDTH=0, HEIGHT=5, START:
   - No sdram_wr_o.
   - done_o pulse in cycle N+1, STATUS=0x2.
4. WIDTH=16, HEIGHT=1, ABORT written after 3 acks while ack withheld:
   - wr held until 4th ack, then idle.
   - Exactly 4 writes, STATUS=0x0, no done_o.
5. DST=0xFFFFFE, WIDTH=4, HEIGHT=1:
   - Addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
6. While busy, write VALUE=0x1234 and START again:
   - Fill continues with the original value and reads back the original VALUE.
   - rst_i asserted mid-fill: wr=0 and busy=0 next cycle; DST reads 0.
